// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the MIPS32 pipeline and its hazard/stall controller.
// The pipeline side (master) drives decode/execute fields; the controller (slave) returns holds and flushes.
interface pipe_stall_ctrl_if;
   logic [4:0] rs_d;
   logic [4:0] rt_d;
   logic       uses_rs_d;
   logic       uses_rt_d;
   logic       memread_e;
   logic       regwrite_e;
   logic [4:0] rf_wa_e;
   logic       md_start_d;
   logic       mfhilo_d;
   logic       branch_taken_d;
   logic       stall_f;
   logic       stall_d;
   logic       flush_d;
   logic       flush_e;
   logic       md_busy;
   logic       md_done;

   modport master (
      output rs_d, rt_d, uses_rs_d, uses_rt_d, memread_e, regwrite_e, rf_wa_e,
             md_start_d, mfhilo_d, branch_taken_d,
      input  stall_f, stall_d, flush_d, flush_e, md_busy, md_done
   );

   modport slave (
      input  rs_d, rt_d, uses_rs_d, uses_rt_d, memread_e, regwrite_e, rf_wa_e,
             md_start_d, mfhilo_d, branch_taken_d,
      output stall_f, stall_d, flush_d, flush_e, md_busy, md_done
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Load-use and mult/div hazard controller: holds PC and F/D, bubbles D/E, flushes F/D on taken branches.
// A small IDLE/BUSY counter FSM shadows the multi-cycle mult/div unit.
module pipe_stall_ctrl #(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 1);

   logic [0:0] r_state;
   logic [7:0] r_cnt;

   logic w_rs_match;
   logic w_rt_match;
   logic w_lu;
   logic w_busy;
   logic w_done;
   logic w_md_haz;
   logic w_stall;
   logic w_md_accept;

   // $0 is hard-wired zero, so a load targeting it can never feed a dependent instruction
   assign w_rs_match = bus.uses_rs_d & (bus.rs_d == bus.rf_wa_e);
   assign w_rt_match = bus.uses_rt_d & (bus.rt_d == bus.rf_wa_e);
   assign w_lu       = bus.memread_e & bus.regwrite_e & (bus.rf_wa_e != 5'd0)
                       & (w_rs_match | w_rt_match);

   assign w_busy      = (r_state == BUSY);
   assign w_done      = w_busy & (r_cnt == 8'd0);
   assign w_md_haz    = w_busy & (bus.mfhilo_d | bus.md_start_d);
   assign w_stall     = w_lu | w_md_haz;
   assign w_md_accept = (r_state == IDLE) & bus.md_start_d & ~w_lu;

   assign bus.stall_f = w_stall;
   assign bus.stall_d = w_stall;
   assign bus.flush_e = w_stall;
   // A held Decode stage re-resolves its branch once released, so the flush waits for that cycle
   assign bus.flush_d = bus.branch_taken_d & ~w_stall;
   assign bus.md_busy = w_busy;
   assign bus.md_done = w_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_md_accept) begin
                  r_state <= BUSY;
                  r_cnt   <= CNT_LOAD;
               end
            end
            BUSY: begin
               if (r_cnt == 8'd0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expectations queued as each step is driven, popped and asserted once outputs settle.
module tb_pipe_stall_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if bus ();
   pipe_stall_ctrl_if bus1 ();

   assign bus1.rs_d           = bus.rs_d;
   assign bus1.rt_d           = bus.rt_d;
   assign bus1.uses_rs_d      = bus.uses_rs_d;
   assign bus1.uses_rt_d      = bus.uses_rt_d;
   assign bus1.memread_e      = bus.memread_e;
   assign bus1.regwrite_e     = bus.regwrite_e;
   assign bus1.rf_wa_e        = bus.rf_wa_e;
   assign bus1.md_start_d     = bus.md_start_d;
   assign bus1.mfhilo_d       = bus.mfhilo_d;
   assign bus1.branch_taken_d = bus.branch_taken_d;

   pipe_stall_ctrl #(.MD_LATENCY(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipe_stall_ctrl #(.MD_LATENCY(1)) u_dut_lat1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Expected vector: {stall_f, stall_d, flush_d, flush_e, md_busy, md_done}
   localparam logic [5:0] E0 = 6'b000000;
   localparam logic [5:0] ES = 6'b110100;
   localparam logic [5:0] EF = 6'b001000;
   localparam logic [5:0] EB = 6'b000010;
   localparam logic [5:0] ED = 6'b000001;

   typedef struct {
      string      tag;
      logic [7:0] exp;
      logic [7:0] mask;
   } sb_t;

   sb_t sb_q[$];
   int  checks   = 0;
   int  failures = 0;

   task automatic zero_inputs();
      bus.rs_d           = 5'd0;
      bus.rt_d           = 5'd0;
      bus.uses_rs_d      = 1'b0;
      bus.uses_rt_d      = 1'b0;
      bus.memread_e      = 1'b0;
      bus.regwrite_e     = 1'b0;
      bus.rf_wa_e        = 5'd0;
      bus.md_start_d     = 1'b0;
      bus.mfhilo_d       = 1'b0;
      bus.branch_taken_d = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] wa);
      bus.memread_e  = 1'b1;
      bus.regwrite_e = 1'b1;
      bus.rf_wa_e    = wa;
      bus.rs_d       = wa;
      bus.uses_rs_d  = 1'b1;
   endtask

   // Advance to just after the next rising edge and clear all inputs
   task automatic nxt();
      @(posedge clk);
      #1;
      zero_inputs();
   endtask

   task automatic check_pop();
      sb_t        e;
      logic [7:0] obs;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty obs=none exp=entry");
      end else begin
         e   = sb_q.pop_front();
         obs = {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e,
                bus.md_busy, bus.md_done, bus1.md_busy, bus1.md_done};
         assert ((obs & e.mask) === (e.exp & e.mask)) else begin
            failures++;
            $display("FAIL %s obs=%b exp=%b mask=%b", e.tag, obs, e.exp, e.mask);
            $error("check %s obs=%b exp=%b", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [5:0] e);
      sb_t s;
      s.tag  = tag;
      s.exp  = {e, 2'b00};
      s.mask = 8'hFC;
      sb_q.push_back(s);
      #1;
      check_pop();
   endtask

   task automatic chk1(input string tag, input logic [5:0] e, input logic [1:0] e1);
      sb_t s;
      s.tag  = tag;
      s.exp  = {e, e1};
      s.mask = 8'hFF;
      sb_q.push_back(s);
      #1;
      check_pop();
   endtask

   initial begin
      rst = 1'b0;
      zero_inputs();
      #2;
      chk("reset_all_zero", E0);
      @(negedge clk);
      rst = 1'b1;

      nxt(); chk("idle_zero", E0);

      // Load-use on rs: exactly one stall cycle, then the bubble removes memread_e
      nxt(); set_lu(5'd8); chk("lu_rs", ES);
      nxt(); chk("lu_one_cycle", E0);
      nxt(); set_lu(5'd0); chk("lu_reg0", E0);
      nxt(); bus.memread_e = 1'b1; bus.regwrite_e = 1'b1; bus.rf_wa_e = 5'd5;
             bus.rt_d = 5'd5; bus.uses_rt_d = 1'b1; chk("lu_rt", ES);
      nxt(); bus.memread_e = 1'b1; bus.regwrite_e = 1'b1; bus.rf_wa_e = 5'd5;
             bus.rt_d = 5'd5; bus.uses_rt_d = 1'b0; chk("lu_rt_unused", E0);
      nxt(); set_lu(5'd9); bus.regwrite_e = 1'b0; chk("lu_no_regwrite", E0);

      // Branch during a load-use stall waits one cycle before flushing
      nxt(); set_lu(5'd3); bus.branch_taken_d = 1'b1; chk("br_during_stall", ES);
      nxt(); bus.branch_taken_d = 1'b1; chk("br_after_stall", EF);

      // Mult/div accepted at T, HI/LO consumer held from T+1
      nxt(); bus.md_start_d = 1'b1; chk1("md_accept", E0, 2'b00);
      nxt(); bus.mfhilo_d = 1'b1; chk1("md_t1", ES | EB, 2'b11);
      nxt(); bus.mfhilo_d = 1'b1; set_lu(5'd7); chk1("md_t2_combined", ES | EB, 2'b00);
      nxt(); bus.mfhilo_d = 1'b1; chk("md_t3", ES | EB);
      nxt(); bus.mfhilo_d = 1'b1; chk("md_t4_done", ES | EB | ED);
      nxt(); bus.mfhilo_d = 1'b1; chk("md_t5_release", E0);

      // Start blocked by load-use, then back-to-back starts
      nxt(); bus.md_start_d = 1'b1; set_lu(5'd4); chk("start_blocked", ES);
      nxt(); bus.md_start_d = 1'b1; chk("start_accept", E0);
      for (int i = 1; i <= 3; i++) begin
         nxt(); bus.md_start_d = 1'b1; chk($sformatf("b2b_busy%0d", i), ES | EB);
      end
      nxt(); bus.md_start_d = 1'b1; chk("b2b_done_stalled", ES | EB | ED);
      nxt(); bus.md_start_d = 1'b1; chk("b2b_second_accept", E0);
      for (int i = 1; i <= 3; i++) begin
         nxt(); chk($sformatf("b2b2_busy%0d", i), EB);
      end
      nxt(); chk("b2b2_done", EB | ED);
      nxt(); chk("b2b2_idle", E0);

      // Asynchronous reset while BUSY with cnt == 2
      nxt(); bus.md_start_d = 1'b1; chk("rst_md_accept", E0);
      nxt(); chk("rst_busy_cnt3", EB);
      nxt(); chk("rst_busy_cnt2", EB);
      #1;
      rst = 1'b0;
      bus.mfhilo_d = 1'b1;
      chk("rst_async_clear", E0);
      set_lu(5'd6);
      chk("rst_lu_still_live", ES);
      zero_inputs();
      @(negedge clk);
      rst = 1'b1;
      nxt(); bus.mfhilo_d = 1'b1; chk("post_rst_mfhi", E0);
      nxt(); bus.mfhilo_d = 1'b1; chk("post_rst_idle", E0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout obs=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench time limit exceeded");
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall controller for the pipelined MIPS32 core. It generates the hold and flush controls consumed by the F/D and D/E pipeline registers and the PC register: `stall_*` = 1 means the register holds, and 0 means it loads. It detects load-use hazards combinationally. It also runs a counter FSM that tracks the multi-cycle multiply/divide unit, stalling any HI/LO consumer or second mult/div until the result is written. Branch redirects flush the F/D register.

## Interface
- `MD_LATENCY`, default 32: cycles the mult/div unit is busy after issue; legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `rs_d` in 5: rs field of the instruction in Decode.
- `rt_d` in 5: rt field of the instruction in Decode.
- `uses_rs_d` in 1: the Decode instruction reads rs.
- `uses_rt_d` in 1: the Decode instruction reads rt.
- `memread_e` in 1: the Execute instruction is a load.
- `regwrite_e` in 1: the Execute instruction writes the register file.
- `rf_wa_e` in 5: destination register of the Execute instruction.
- `md_start_d` in 1: the Decode instruction is mult/multu/div/divu.
- `mfhilo_d` in 1: the Decode instruction is mfhi/mflo.
- `branch_taken_d` in 1: a branch/jump resolved taken in Decode.
- `stall_f` out 1: hold the PC register.
- `stall_d` out 1: hold the F/D register.
- `flush_d` out 1: clear the F/D register (insert a nop).
- `flush_e` out 1: clear the D/E register control (insert a bubble).
- `md_busy` out 1: the mult/div unit is busy (state BUSY).
- `md_done` out 1: one-cycle pulse in the final BUSY cycle.

## Operation
- Load-use term `lu`:
  - `lu` = `memread_e` & `regwrite_e` & (`rf_wa_e` != 0) & ((`uses_rs_d` & `rs_d` == `rf_wa_e`) | (`uses_rt_d` & `rt_d` == `rf_wa_e`)).
- Mult/div term `md_haz`:
  - `md_haz` = (state == BUSY) & (`mfhilo_d` | `md_start_d`).
- Stall and flush outputs:
  - `stall_f` = `stall_d` = `flush_e` = `lu` | `md_haz`.
  - `flush_d` = `branch_taken_d` & ~`stall_d`. A stall suppresses the flush, because the branch re-resolves when Decode is released.
- FSM states: IDLE and BUSY. The counter `cnt` is 8 bits.
- IDLE -> BUSY:
  - Condition: `md_start_d` & ~`lu`. The instruction is accepted that cycle.
  - Action: `cnt` <= `MD_LATENCY`-1.
  - If `lu` is also asserted, the start is not accepted; the instruction is re-presented next cycle.
- BUSY:
  - `cnt` != 0: `cnt` decrements by 1 per cycle.
  - `cnt` == 0: `md_done` = 1 and the state returns to IDLE.
  - A new `md_start_d` seen during BUSY, including the done cycle, is stalled. It is accepted in the first IDLE cycle.
- `md_busy` = (state == BUSY). `md_done` = BUSY & (`cnt` == 0).
- Reset (`rst` = 0), at any time including mid-BUSY:
  - State -> IDLE and `cnt` -> 0 immediately.
  - `md_busy` and `md_done` go to 0 immediately.
  - The stall/flush outputs follow only the combinational `lu` and `branch_taken_d` terms.
  - With all inputs at 0, every output is 0.

## Timing
- `lu`, `md_haz`, all stall/flush outputs and `md_done` are combinational from the current state and inputs. There are no registered outputs other than the state that drives `md_busy`.
- Mult/div accepted in cycle T:
  - `md_busy` is high in cycles T+1 .. T+`MD_LATENCY`.
  - `md_done` is high in cycle T+`MD_LATENCY`.
  - The first `mfhilo_d` is unstalled in cycle T+`MD_LATENCY`+1.
- `MD_LATENCY` = 1: BUSY lasts exactly one cycle, and `md_done` is asserted in it.
- A load-use stall lasts exactly one cycle. The next cycle the load is in Mem, so `memread_e` is 0 because of the bubble.
- Simultaneous `lu` and `md_haz`: a single combined stall; no double bubble.
- Register $0 never causes a load-use stall.

## Test plan
- Load-use hazard:
  - Stimulus: `memread_e`=1, `regwrite_e`=1, `rf_wa_e`=8, `rs_d`=8, `uses_rs_d`=1.
  - Response: `stall_f`=`stall_d`=`flush_e`=1 for that cycle only; same stimulus with `rf_wa_e`=0 -> all three 0.
- Mult/div with HI/LO consumer (`MD_LATENCY`=4):
  - Stimulus: `md_start_d` pulsed at cycle 10, then `mfhilo_d` held high from cycle 11.
  - Response: `md_busy` high in cycles 11-14; `md_done` high in cycle 14; stall high in cycles 11-14 and low in cycle 15.
- Back-to-back mult/div:
  - Stimulus: second `md_start_d` held high during BUSY.
  - Response: stalled until IDLE, then accepted; `md_busy` re-asserts the cycle after acceptance.
- Branch during stall:
  - Stimulus: `branch_taken_d`=1 with `lu`=1.
  - Response: `flush_d`=0; the next cycle, with `lu`=0 -> `flush_d`=1.
- Start blocked by load-use:
  - Stimulus: `md_start_d`=1 together with `lu`=1.
  - Response: state stays IDLE; accepted the following cycle.
- Reset mid-BUSY:
  - Stimulus: `rst` driven to 0 at `cnt`=2.
  - Response: `md_busy` and `md_done` fall asynchronously; after release, the state is IDLE and `mfhilo_d` is not stalled.
